// File: rtl/subtract_pkg.sv
// Shared types and constants for the multiword subtract sequencer.
package subtract_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/subtract_slice4.sv
// 4-bit subtract slice with borrow in/out.
module subtract_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bo
);

  logic [4:0] res;

  // Bit 4 of the 5-bit difference is set exactly when a - b - bin is negative.
  always_comb begin
    res = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    d   = res[3:0];
    bo  = res[4];
  end

endmodule

// File: rtl/multiword_subtract_sequencer.sv
// WIDTH-bit subtract A - B using one 4-bit slice, least-significant nibble first.
module multiword_subtract_sequencer
  import subtract_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_nx;
  logic [IDX_W-1:0] idx;
  logic             bin;
  logic             borrow_q, ovf_q, zero_q;

  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_d;
  logic                slice_bo;

  // Select the operand nibbles for the current index and merge the slice result.
  always_comb begin
    slice_a = a_q[int'(idx) * NIBBLE_W +: NIBBLE_W];
    slice_b = b_q[int'(idx) * NIBBLE_W +: NIBBLE_W];
    diff_nx = diff_q;
    diff_nx[int'(idx) * NIBBLE_W +: NIBBLE_W] = slice_d;
  end

  subtract_slice4 u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .bin (bin),
    .d   (slice_d),
    .bo  (slice_bo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, nibble sequencing and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      idx      <= '0;
      bin      <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            bin <= 1'b0;
            idx <= '0;
          end
        end
        RUN: begin
          diff_q <= diff_nx;
          bin    <= slice_bo;
          if (idx != LAST_IDX) begin
            idx <= idx + 1'b1;
          end else begin
            // The last nibble holds the sign bit, so slice_d[3] is the final diff msb.
            borrow_q <= slice_bo;
            ovf_q    <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (slice_d[NIBBLE_W-1] ^ a_q[WIDTH-1]);
            zero_q   <= (diff_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_multiword_subtract_sequencer.sv
// Bench for multiword_subtract_sequencer (WIDTH=16).
module tb_multiword_subtract_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out, overflow, zero, busy;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bo;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t        tbl[6];
  vec_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  multiword_subtract_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow),
    .zero       (zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    vec_t v;
    v.a    = x;
    v.b    = y;
    v.diff = x - y;
    v.bo   = (x < y);
    v.ov   = (x[W-1] ^ y[W-1]) & (v.diff[W-1] ^ x[W-1]);
    v.z    = (v.diff == '0);
    return v;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [W-1:0] d, input logic bo, input logic ov, input logic z);
    vec_t v;
    v.a = x; v.b = y; v.diff = d; v.bo = bo; v.ov = ov; v.z = z;
    return v;
  endfunction

  // Drive one operand pair through the input handshake; expected result goes to the scoreboard.
  task automatic send(input vec_t v, input bit track);
    int unsigned n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    a        = v.a;
    b        = v.b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (track) sb.push_back(v);
  endtask

  // Wait for out_valid, compare against the scoreboard head, then complete the output handshake.
  task automatic recv(input bit check_lat);
    int unsigned n = 0;
    vec_t e;
    while (!out_valid && n < 20) begin
      chk("in_ready_while_busy", {31'b0, in_ready}, 32'd0);
      tick();
      n++;
    end
    chk("out_valid_seen", {31'b0, out_valid}, 32'd1);
    if (check_lat) chk("latency", n, 32'd4);
    chk("no_in_ready_in_done", {31'b0, in_ready}, 32'd0);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("diff", {16'b0, diff}, {16'b0, e.diff});
      chk("borrow_out", {31'b0, borrow_out}, {31'b0, e.bo});
      chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
      chk("zero", {31'b0, zero}, {31'b0, e.z});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_cleared", {31'b0, out_valid}, 32'd0);
    chk("in_ready_after_handshake", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] held_diff;
    logic [2:0]   held_flags;

    tbl[0] = mk(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tbl[2] = mk(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    tbl[3] = mk(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);
    tbl[4] = mk(16'h5A5A, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[5] = mk(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    tick();
    tick();

    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_diff", {16'b0, diff}, 32'd0);
    chk("rst_flags", {29'b0, borrow_out, overflow, zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    // out_ready while idle must do nothing.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_out_ready_no_effect", {30'b0, out_valid, in_ready}, 32'd1);

    for (int unsigned i = 0; i < 6; i++) begin
      send(tbl[i], 1'b1);
      chk("busy_in_run", {31'b0, busy}, 32'd1);
      recv(1'b1);
    end

    for (int unsigned i = 0; i < 4; i++) begin
      send(model(W'($urandom), W'($urandom)), 1'b1);
      recv(1'b1);
    end

    // Back-pressure: hold DONE for 10 cycles while pulsing in_valid with new operands.
    send(mk(16'h9000, 16'h1000, 16'h8000, 1'b0, 1'b0, 1'b0), 1'b1);
    begin
      int unsigned n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
    end
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    held_diff  = diff;
    held_flags = {borrow_out, overflow, zero};
    for (int unsigned i = 0; i < 10; i++) begin
      in_valid = i[0];
      a        = 16'hDEAD;
      b        = 16'hBEEF;
      tick();
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_no_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_diff_stable", {16'b0, diff}, {16'b0, held_diff});
      chk("bp_flags_stable", {29'b0, borrow_out, overflow, zero}, {29'b0, held_flags});
    end
    in_valid = 1'b0;
    recv(1'b0);
    send(tbl[2], 1'b1);
    recv(1'b1);

    // Reset during the second RUN cycle aborts the operation.
    send(tbl[1], 1'b0);
    tick();
    chk("pre_abort_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_diff", {16'b0, diff}, 32'd0);
    chk("abort_flags", {29'b0, borrow_out, overflow, zero}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      chk("abort_no_out_valid", {31'b0, out_valid}, 32'd0);
    end
    send(mk(16'h0003, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0), 1'b1);
    recv(1'b1);

    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiword_subtract_sequencer.md
# multiword_subtract_sequencer

Sequencer that performs a WIDTH-bit two's-complement subtraction A − B by time-multiplexing a single 4-bit subtract slice, one nibble per clock, least-significant nibble first, with the borrow chained between cycles. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It reports the difference, the unsigned borrow-out, the signed overflow and a zero flag. It is used wherever a wide subtract is needed but a full-width subtractor is too costly.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 8
- NIBBLES, WIDTH/4, derived local constant; number of RUN cycles
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- diff  out  WIDTH  A − B mod 2^WIDTH
- borrow_out  out  1  1 when A < B unsigned (inverse of carry-out)
- overflow  out  1  signed overflow: (A[msb] ^ B[msb]) & (diff[msb] ^ A[msb])
- zero  out  1  diff == 0
- busy  out  1  state is RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch a and b, clear borrow-in, set nibble index to 0, and go to RUN. in_valid while not IDLE is ignored.
- RUN: each cycle the slice computes {bo, d} = a[idx] − b[idx] − bin (4-bit nibbles). d is written to diff[idx], and bin is set to bo.
  - If idx < NIBBLES−1: increment idx.
  - Otherwise: register borrow_out=bo, overflow per the formula above using the latched A and B and the final diff, and zero; then go to DONE.
- DONE: out_valid=1. diff and all flags are held stable until out_ready is sampled high, then return to IDLE.
- Arithmetic: the nibble slice is 5-bit internally (a − b − bin); bo = result bit 4. The index counter is $clog2(NIBBLES) bits wide and does not wrap during RUN.
- diff and the flags are only meaningful while out_valid=1. During RUN, diff changes one nibble per cycle.

## Timing
- Reset (async assert, sync deassert at the block's boundary): state IDLE, in_ready=1, out_valid=0, busy=0, diff=0, borrow_out=0, overflow=0, zero=0, internal latches cleared.
- Latency: an input handshake at edge k gives out_valid=1 after edge k+NIBBLES (4 cycles for WIDTH=16).
- Throughput: in_ready rises the cycle after the output handshake, so the minimum issue interval is NIBBLES+2 cycles.
- in_ready and out_valid are never high in the same cycle.
- Back-pressure: out_ready low holds DONE indefinitely with outputs unchanged.
- Reset mid-RUN or mid-DONE aborts the operation: no out_valid, and no partial result is delivered.
- out_ready high while out_valid=0 has no effect.

## Structure
- Shared package `subtract_pkg`: state enum typedef (IDLE, RUN, DONE) and a NIBBLE_W=4 constant.
- Sub-module `subtract_slice4`: combinational, with inputs a[3:0], b[3:0], bin and outputs d[3:0], bo. Instantiated once.
- The top holds the FSM, operand registers, index counter, borrow register and result registers.

## Test plan
All scenarios use WIDTH=16.
- 0x1234 − 0x0234 → diff=0x1000, borrow_out=0, overflow=0, zero=0; out_valid exactly 4 cycles after acceptance.
- 0x0000 − 0x0001 → diff=0xFFFF, borrow_out=1, overflow=0 (borrow ripples through all 4 nibbles).
- 0x8000 − 0x0001 → diff=0x7FFF, borrow_out=0, overflow=1. Also 0x7FFF − 0xFFFF → diff=0x8000, overflow=1, borrow_out=1.
- 0x5A5A − 0x5A5A → diff=0x0000, zero=1, borrow_out=0, overflow=0.
- Hold out_ready low for 10 cycles in DONE with in_valid pulsed:
  - out_valid stays 1, outputs are stable, in_ready stays 0, and the new operands are ignored.
  - After out_ready=1, in_ready=1 on the next cycle and the next operation is correct.
- Assert rst_n low during the second RUN cycle of 0x0000 − 0x0001:
  - All outputs go to reset values immediately and out_valid never appears for that operation.
  - After release, 0x0003 − 0x0001 gives diff=0x0002.
